instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit for the downsampling processor. It reads the current program counter value off the B bus and issues a single-beat read to the synchronous instruction memory. It captures the returned word into an instruction register and hands it to the control unit over a valid/ready handshake. A flush discards any in-flight or held instruction after jumps.

## Interface
Parameters:
- ADDR_W, 16, width of PC / instruction memory address
- INSTR_W, 16, width of instruction word
- CNT_W, 16, width of retired-fetch counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- pc_in  in  ADDR_W  current PC value from the B bus
- fetch_req  in  1  control unit requests instruction at pc_in
- flush  in  1  abandon in-flight/held instruction (jump taken)
- imem_addr  out  ADDR_W  registered read address to instruction memory
- imem_rd_en  out  1  registered read strobe, one cycle per read
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_rd_en
- ir_valid  out  1  ir_data holds a fetched instruction
- ir_data  out  INSTR_W  fetched instruction
- ir_pc  out  ADDR_W  address ir_data was fetched from
- ir_ready  in  1  control unit consumes ir_data when high with ir_valid
- fetch_busy  out  1  high in READ or WAIT
- fetch_count  out  CNT_W  number of completed ir handshakes

## Operation
- States: IDLE, READ, WAIT, VALID.
- IDLE:
  - If fetch_req=1 and flush=0: latch pc_in into imem_addr and into an internal addr tag, set imem_rd_en=1, go to READ.
  - Otherwise stay.
- READ: imem_rd_en=0 next, go to WAIT. fetch_req ignored, not queued.
- WAIT:
  - Capture imem_rdata into ir_data and the addr tag into ir_pc.
  - Set ir_valid=1, go to VALID.
  - fetch_req ignored.
- VALID:
  - Hold ir_data, ir_pc and ir_valid stable until ir_valid & ir_ready.
  - On handshake, increment fetch_count (wraps 2^CNT_W−1 → 0).
    - If fetch_req=1 in the same cycle: load pc_in, imem_rd_en=1, go to READ (back-to-back).
    - Otherwise ir_valid=0, go to IDLE.
- flush=1 in any state: next state IDLE.
  - ir_valid=0 and imem_rd_en=0.
  - Data returning for a flushed read is never captured.
  - fetch_count unchanged, even if a handshake coincides with flush.
  - flush beats fetch_req in the same cycle.
- ir_data and ir_pc keep their last values when ir_valid=0. Consumers must not use them then.
- Reset (rst_n=0 at a rising edge) from any state, including mid-read:
  - State goes to IDLE.
  - imem_addr, imem_rd_en, ir_valid, ir_data, ir_pc, fetch_busy and fetch_count all become 0.
  - A read outstanding at reset is discarded.

## Timing
- Accept edge E0 (IDLE, fetch_req=1): imem_rd_en=1 and imem_addr=pc_in(E0) during the cycle after E0.
- Memory data is valid after E1. It is captured at E2, and ir_valid=1 after E2.
- Request-to-valid latency is 2 cycles.
- Back-to-back throughput is one instruction per 3 cycles (VALID→READ→WAIT→VALID).
- fetch_busy is a combinational decode of state (READ|WAIT).
- All other outputs are registered.
- pc_in is sampled only at accept edges. It may change freely otherwise.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, READ, WAIT, VALID);
  - the default ADDR_W and INSTR_W constants shared with the PC and instruction memory.
- Single module; no sub-module is needed. The state register, addr tag, instruction register and counter are all inline.

## Test plan
- Reset with garbage state and rst_n=0 for 2 cycles → all outputs 0, state IDLE, no imem_rd_en.
- pc_in=0x0010, fetch_req pulse, memory returns 0xA5C3 → one imem_rd_en pulse with imem_addr=0x0010. ir_valid rises 2 cycles after accept with ir_data=0xA5C3 and ir_pc=0x0010. After ir_ready, fetch_count=1.
- ir_ready held low for 5 cycles → ir_data/ir_pc stable and no new imem_rd_en. The handshake with fetch_req=1 and pc_in=0x0011 causes an immediate READ at 0x0011.
- flush asserted during WAIT → ir_valid stays 0, the returned word is discarded, state IDLE. A next fetch at 0x0040 completes normally.
- fetch_count preset near wrap via 0xFFFF handshakes (or CNT_W=4 with 15 handshakes) → next handshake yields 0.
- fetch_req and flush high together in IDLE, then rst_n=0 during READ → no read issued in the first case. The second case gives IDLE with all outputs 0 on the next edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch state encoding and bus widths
package fetch_pkg;

    localparam int ADDR_W_DEF  = 16;
    localparam int INSTR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory port and instruction register handshake
interface instr_fetch_if #(
    parameter int ADDR_W  = fetch_pkg::ADDR_W_DEF,
    parameter int INSTR_W = fetch_pkg::INSTR_W_DEF
);
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_rd_en;
    logic [INSTR_W-1:0] imem_rdata;
    logic               ir_valid;
    logic [INSTR_W-1:0] ir_data;
    logic [ADDR_W-1:0]  ir_pc;
    logic               ir_ready;

    modport master (
        output imem_addr, imem_rd_en, ir_valid, ir_data, ir_pc,
        input  imem_rdata, ir_ready
    );

    modport slave (
        input  imem_addr, imem_rd_en, ir_valid, ir_data, ir_pc,
        output imem_rdata, ir_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-beat instruction fetch into a valid/ready instruction register
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              fetch_req,
    input  logic              flush,
    instr_fetch_if.master     bus,
    output logic              fetch_busy,
    output logic [CNT_W-1:0]  fetch_count
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rd_en_q, rd_en_d;
    logic               ir_valid_q, ir_valid_d;
    logic [INSTR_W-1:0] ir_data_q, ir_data_d;
    logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic handshake;
    assign handshake = (state_q == ST_VALID) && ir_valid_q && bus.ir_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (fetch_req) state_d = ST_READ;
                ST_READ:  state_d = ST_WAIT;
                ST_WAIT:  state_d = ST_VALID;
                ST_VALID: if (handshake) state_d = fetch_req ? ST_READ : ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // imem_addr doubles as the address tag: it only changes at accept edges.
    always_comb begin
        addr_d     = addr_q;
        rd_en_d    = 1'b0;
        ir_valid_d = ir_valid_q;
        ir_data_d  = ir_data_q;
        ir_pc_d    = ir_pc_q;
        cnt_d      = cnt_q;
        if (flush) begin
            ir_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_req) begin
                        addr_d  = pc_in;
                        rd_en_d = 1'b1;
                    end
                end
                ST_WAIT: begin
                    ir_data_d  = bus.imem_rdata;
                    ir_pc_d    = addr_q;
                    ir_valid_d = 1'b1;
                end
                ST_VALID: begin
                    if (handshake) begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        ir_valid_d = 1'b0;
                        if (fetch_req) begin
                            addr_d  = pc_in;
                            rd_en_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            ir_valid_q <= 1'b0;
            ir_data_q  <= '0;
            ir_pc_q    <= '0;
            cnt_q      <= '0;
        end else begin
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            ir_valid_q <= ir_valid_d;
            ir_data_q  <= ir_data_d;
            ir_pc_q    <= ir_pc_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.imem_addr  = addr_q;
    assign bus.imem_rd_en = rd_en_q;
    assign bus.ir_valid   = ir_valid_q;
    assign bus.ir_data    = ir_data_q;
    assign bus.ir_pc      = ir_pc_q;
    assign fetch_busy     = (state_q == ST_READ) || (state_q == ST_WAIT);
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a synchronous memory model
module tb_instr_fetch;

    localparam int AW = 16;
    localparam int IW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] pc_in;
    logic          fetch_req;
    logic          flush;
    logic          fetch_busy;
    logic [CW-1:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;
    int rd_pulses = 0;
    int rd_mark;

    instr_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    instr_fetch #(.ADDR_W(AW), .INSTR_W(IW), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .fetch_req   (fetch_req),
        .flush       (flush),
        .bus         (bus),
        .fetch_busy  (fetch_busy),
        .fetch_count (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
        case (a)
            16'h0010: return 16'hA5C3;
            16'h0011: return 16'h1234;
            16'h0020: return 16'hDEAD;
            16'h0040: return 16'hBEEF;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.imem_rd_en) begin
            bus.imem_rdata <= mem_word(bus.imem_addr);
            rd_pulses = rd_pulses + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".addr"},  32'(bus.imem_addr),  32'h0);
        check({tag, ".rd_en"}, 32'(bus.imem_rd_en), 32'h0);
        check({tag, ".valid"}, 32'(bus.ir_valid),   32'h0);
        check({tag, ".data"},  32'(bus.ir_data),    32'h0);
        check({tag, ".pc"},    32'(bus.ir_pc),      32'h0);
        check({tag, ".busy"},  32'(fetch_busy),     32'h0);
        check({tag, ".count"}, 32'(fetch_count),    32'h0);
    endtask

    task automatic fetch_and_consume(input logic [AW-1:0] a);
        fetch_req = 1'b1; pc_in = a;
        step();
        fetch_req = 1'b0;
        step();
        step();
        check("loop.data", 32'(bus.ir_data), 32'(a ^ 16'h5A5A));
        bus.ir_ready = 1'b1;
        step();
        bus.ir_ready = 1'b0;
    endtask

    initial begin
        bus.imem_rdata = 16'hFFFF;
        rst_n = 1'b0; fetch_req = 1'b1; flush = 1'b0; pc_in = 16'hFFFF;
        bus.ir_ready = 1'b1;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1; fetch_req = 1'b0; bus.ir_ready = 1'b0;
        step();
        check("idle.busy", 32'(fetch_busy), 32'h0);

        // single fetch at 0x0010
        rd_mark = rd_pulses;
        pc_in = 16'h0010; fetch_req = 1'b1;
        step();
        check("e0.rd_en", 32'(bus.imem_rd_en), 32'h1);
        check("e0.addr",  32'(bus.imem_addr),  32'h0010);
        check("e0.busy",  32'(fetch_busy),     32'h1);
        fetch_req = 1'b0; pc_in = 16'h9999;
        step();
        check("e1.rd_en", 32'(bus.imem_rd_en), 32'h0);
        check("e1.valid", 32'(bus.ir_valid),   32'h0);
        check("e1.busy",  32'(fetch_busy),     32'h1);
        step();
        check("e2.valid", 32'(bus.ir_valid), 32'h1);
        check("e2.data",  32'(bus.ir_data),  32'hA5C3);
        check("e2.pc",    32'(bus.ir_pc),    32'h0010);
        check("e2.busy",  32'(fetch_busy),   32'h0);
        check("e2.pulses", 32'(rd_pulses - rd_mark), 32'h1);

        // stall with ir_ready low
        rd_mark = rd_pulses;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall.valid", 32'(bus.ir_valid), 32'h1);
            check("stall.data",  32'(bus.ir_data),  32'hA5C3);
            check("stall.pc",    32'(bus.ir_pc),    32'h0010);
        end
        check("stall.pulses", 32'(rd_pulses - rd_mark), 32'h0);

        // back-to-back handshake + request
        bus.ir_ready = 1'b1; fetch_req = 1'b1; pc_in = 16'h0011;
        step();
        check("b2b.count", 32'(fetch_count),    32'h1);
        check("b2b.rd_en", 32'(bus.imem_rd_en), 32'h1);
        check("b2b.addr",  32'(bus.imem_addr),  32'h0011);
        check("b2b.valid", 32'(bus.ir_valid),   32'h0);
        bus.ir_ready = 1'b0; fetch_req = 1'b0;
        step();
        step();
        check("b2b.data2", 32'(bus.ir_data), 32'h1234);
        check("b2b.pc2",   32'(bus.ir_pc),   32'h0011);
        bus.ir_ready = 1'b1;
        step();
        check("b2b.count2", 32'(fetch_count), 32'h2);
        check("b2b.idle",   32'(bus.ir_valid), 32'h0);
        bus.ir_ready = 1'b0;

        // flush during WAIT
        pc_in = 16'h0020; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.valid", 32'(bus.ir_valid), 32'h0);
        check("flush.busy",  32'(fetch_busy),   32'h0);
        step();
        check("flush.valid2", 32'(bus.ir_valid), 32'h0);
        check("flush.keep",   32'(bus.ir_data),  32'h1234);
        pc_in = 16'h0040; fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        step();
        step();
        check("post.valid", 32'(bus.ir_valid), 32'h1);
        check("post.data",  32'(bus.ir_data),  32'hBEEF);
        check("post.pc",    32'(bus.ir_pc),    32'h0040);

        // handshake coinciding with flush is not counted
        bus.ir_ready = 1'b1; flush = 1'b1;
        step();
        check("hsflush.count", 32'(fetch_count),  32'h2);
        check("hsflush.valid", 32'(bus.ir_valid), 32'h0);
        bus.ir_ready = 1'b0; flush = 1'b0;

        // counter wrap with CNT_W=4
        for (int i = 0; i < 13; i++) fetch_and_consume(AW'(16'h0100 + i));
        check("wrap.15", 32'(fetch_count), 32'hF);
        fetch_and_consume(16'h0200);
        check("wrap.0", 32'(fetch_count), 32'h0);

        // flush beats fetch_req in IDLE
        rd_mark = rd_pulses;
        fetch_req = 1'b1; flush = 1'b1; pc_in = 16'h0077;
        step();
        check("both.rd_en", 32'(bus.imem_rd_en), 32'h0);
        check("both.busy",  32'(fetch_busy),     32'h0);
        flush = 1'b0; fetch_req = 1'b0;
        step();
        check("both.pulses", 32'(rd_pulses - rd_mark), 32'h0);

        // reset mid-read
        pc_in = 16'h0050; fetch_req = 1'b1;
        step();
        check("rr.rd_en", 32'(bus.imem_rd_en), 32'h1);
        fetch_req = 1'b0; rst_n = 1'b0;
        step();
        check_all_zero("rr");
        rst_n = 1'b1;
        step();
        step();
        check("rr.valid_after", 32'(bus.ir_valid), 32'h0);
        check("rr.busy_after",  32'(fetch_busy),   32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
